regfile_ctrl: RTL and testbench
===============================

Name: regfile_ctrl

Overview:
Parametrised successor to the processor's 1-write/2-read register file wrapper. Width and depth are configurable. R31-style hardwired-zero register. Optional same-cycle write-to-read bypass. Sequential clear engine zeroes the storage after reset or on request, so the array needs no reset and maps to distributed RAM. Sits between instruction decode (ra/rb/rc fields, ra2sel, werf) and the ALU/writeback path.

Parameters:
DATA_W, 32, data width of each register
ADDR_W, 5, register address width; depth = 2**ADDR_W
ZERO_REG, 31, index that always reads 0 and ignores writes
BYPASS, 1, 1 = a write in the current cycle forwards to matching read ports combinationally; 0 = reads show old contents

Ports:
clk_i  in  1  system clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
ra_i  in  ADDR_W  read port 1 address
rb_i  in  ADDR_W  read port 2 address when ra2sel_i=0
rc_i  in  ADDR_W  write address; read port 2 address when ra2sel_i=1
ra2sel_i  in  1  port 2 address select: 1 = rc_i, 0 = rb_i
werf_i  in  1  write enable
wd_i  in  DATA_W  write data
clr_i  in  1  request a full clear (single-cycle pulse or level)
rd1_o  out  DATA_W  read data port 1
rd2_o  out  DATA_W  read data port 2
busy_o  out  1  clear in progress; writes blocked

Behaviour:
- Reset (rst_n_i low, async): FSM enters CLEAR; clear index = 0; busy_o = 1. rd1_o and rd2_o read 0 while busy. Array contents are not reset directly.
- FSM states: CLEAR, IDLE.
  - CLEAR: each rising edge writes 0 to array[index], then index increments. The edge that writes index 2**ADDR_W-1 moves the FSM to IDLE and drops busy_o. CLEAR lasts exactly 2**ADDR_W cycles after reset deassertion (32 by default).
  - IDLE: clr_i=1 at an edge moves to CLEAR with index = 0 and busy_o=1 from the next cycle.
- clr_i while already in CLEAR is ignored; the sweep does not restart.
- Reset asserted mid-clear restarts the sweep from index 0.
- Writes in IDLE: if werf_i=1 and rc_i != ZERO_REG, array[rc_i] <= wd_i at the rising edge. Writes to ZERO_REG are discarded.
- Writes in CLEAR: werf_i is ignored. There is no queueing and no error flag; the producer must observe busy_o.
- Reads are combinational, from ra_i and ra2 = ra2sel_i ? rc_i : rb_i.
- Read priority, per port:
  1. busy_o = 1 -> 0
  2. address == ZERO_REG -> 0
  3. BYPASS=1, werf_i=1, and rc_i == address -> wd_i
  4. otherwise -> array[address]
- Both ports may address the same register; both return the identical value.
- With ra2sel_i=1 and werf_i=1, port 2 addresses the register being written. With BYPASS=1, rd2_o = wd_i in that cycle.
- Clear index width is ADDR_W. Termination is by compare against all-ones, not by overflow.
- ZERO_REG must be < 2**ADDR_W. This is checked with an elaboration-time assertion.

Decomposition:
- Package rf_pkg holds:
  - state enum rf_state_e {RF_CLEAR, RF_IDLE}
  - default constants RF_DATA_W=32, RF_ADDR_W=5, RF_ZERO_REG=31
- Sub-module regfile_mem holds the storage array: parametrised DATA_W/ADDR_W, one synchronous write port (addr, data, en), two asynchronous read ports, no reset.
- regfile_ctrl holds the FSM, clear counter, write muxing (clear vs. normal), zero-register masking and bypass muxes.

Test Plan:
- Reset then idle: release rst_n_i; busy_o stays 1 for exactly 32 cycles. After that, reading every address 0..31 on both ports returns 0x00000000.
- Write/read: write 0xDEADBEEF to r5 and 0x12345678 to r7. Set ra_i=5, rb_i=7, ra2sel_i=0 -> rd1_o=0xDEADBEEF, rd2_o=0x12345678.
- Zero register: write 0xFFFFFFFF to r31 -> rd1_o with ra_i=31 reads 0. No other register changes.
- Bypass: werf_i=1, rc_i=3, wd_i=0xA5A5A5A5, ra_i=3, ra2sel_i=1 in the same cycle -> rd1_o=rd2_o=0xA5A5A5A5 before the edge. With BYPASS=0 both ports show the old r3 value until after the edge.
- Clear request: r9=0x55 in IDLE; pulse clr_i -> busy_o=1 for 32 cycles. A write of 0x77 to r9 issued during busy is dropped; r9 reads 0 afterwards. A second clr_i pulse mid-sweep does not extend busy_o.
- Reset mid-clear: assert rst_n_i at sweep index 10 and release it -> busy_o lasts a full 32 cycles from release; all registers read 0 at the end.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and default sizing for the register file controller.
//   rf_state_e  : controller state (RF_CLEAR sweeping zeros, RF_IDLE normal)
//   RF_DATA_W   : default register width
//   RF_ADDR_W   : default address width (depth = 2**RF_ADDR_W)
//   RF_ZERO_REG : default hardwired-zero register index
package rf_pkg;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_IDLE  = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_ZERO_REG = 31;

endpackage

// File: rtl/regfile_ctrl_if.sv
// Decode/writeback-side bus of the register file.
//   ra_i, rb_i, rc_i : read 1 / read 2 / write (and alternate read 2) addresses
//   ra2sel_i         : read port 2 address select (1 = rc_i, 0 = rb_i)
//   werf_i, wd_i     : write enable and data
//   clr_i            : full clear request
//   rd1_o, rd2_o     : combinational read data
//   busy_o           : clear sweep running
//
// Write handshake: werf_i is a request that is accepted at a rising edge only
// when busy_o is 0 at that edge; while busy_o is 1 the request is dropped
// (no queueing, no error), so the producer must hold off until busy_o is 0.
// clr_i is accepted only when busy_o is 0 and is ignored otherwise.
interface regfile_ctrl_if
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);
  logic [ADDR_W-1:0] ra_i;
  logic [ADDR_W-1:0] rb_i;
  logic [ADDR_W-1:0] rc_i;
  logic              ra2sel_i;
  logic              werf_i;
  logic [DATA_W-1:0] wd_i;
  logic              clr_i;
  logic [DATA_W-1:0] rd1_o;
  logic [DATA_W-1:0] rd2_o;
  logic              busy_o;

  modport master (
    output ra_i, rb_i, rc_i, ra2sel_i, werf_i, wd_i, clr_i,
    input  rd1_o, rd2_o, busy_o
  );

  modport slave (
    input  ra_i, rb_i, rc_i, ra2sel_i, werf_i, wd_i, clr_i,
    output rd1_o, rd2_o, busy_o
  );
endinterface

// File: rtl/regfile_mem.sv
// Register storage: one synchronous write port, two asynchronous read ports.
// No reset so the array maps onto distributed RAM; the controller zeroes it.
//   clk_i              : clock
//   we_i/waddr_i/wdata_i : write port
//   raddr1_i/rdata1_o  : read port 1
//   raddr2_i/rdata2_o  : read port 2
module regfile_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata1_o = mem[raddr1_i];
  assign rdata2_o = mem[raddr2_i];
endmodule

// File: rtl/regfile_ctrl.sv
// Register file controller: clear-sweep FSM, write muxing, zero-register
// masking and optional write-to-read bypass around regfile_mem.
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset (restarts the clear sweep)
//   bus     : decode/writeback bus (regfile_ctrl_if.slave)
//   state_o : current controller state for observation
module regfile_ctrl
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = RF_ZERO_REG,
  parameter int BYPASS   = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  regfile_ctrl_if.slave    bus,
  output rf_state_e        state_o
);
  if (ZERO_REG < 0 || ZERO_REG >= (2**ADDR_W)) begin : g_zero_reg_check
    $error("regfile_ctrl: ZERO_REG must lie in 0 .. 2**ADDR_W-1");
  end

  localparam logic [0:0]        S_CLEAR   = RF_CLEAR;
  localparam logic [0:0]        S_IDLE    = RF_IDLE;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [0:0]        state_q;
  logic [ADDR_W-1:0] clr_idx_q;
  logic              busy;
  logic [ADDR_W-1:0] ra2;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rd1;
  logic [DATA_W-1:0] mem_rd2;

  // The sweep ends by comparing the index against all-ones; the index then
  // wraps back to 0 on its own, which is also the start value for a new sweep.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          clr_idx_q <= clr_idx_q + 1'b1;
          if (clr_idx_q == '1) state_q <= S_IDLE;
        end
        default: begin
          if (bus.clr_i) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= '0;
          end
        end
      endcase
    end
  end

  assign busy    = (state_q == S_CLEAR);
  assign state_o = rf_state_e'(state_q);
  assign ra2     = bus.ra2sel_i ? bus.rc_i : bus.rb_i;

  // The sweep owns the write port while busy; normal writes are dropped then.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.rc_i;
    mem_wdata = bus.wd_i;
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = clr_idx_q;
      mem_wdata = '0;
    end else if (bus.werf_i && (bus.rc_i != ZERO_ADDR)) begin
      mem_we    = 1'b1;
    end
  end

  regfile_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i    (clk_i),
    .we_i     (mem_we),
    .waddr_i  (mem_waddr),
    .wdata_i  (mem_wdata),
    .raddr1_i (bus.ra_i),
    .raddr2_i (ra2),
    .rdata1_o (mem_rd1),
    .rdata2_o (mem_rd2)
  );

  // Read priority per port: busy, zero register, bypass, array.
  always_comb begin
    bus.rd1_o = mem_rd1;
    if (busy || bus.ra_i == ZERO_ADDR) begin
      bus.rd1_o = '0;
    end else if (BYPASS != 0 && bus.werf_i && bus.rc_i == bus.ra_i) begin
      bus.rd1_o = bus.wd_i;
    end
  end

  always_comb begin
    bus.rd2_o = mem_rd2;
    if (busy || ra2 == ZERO_ADDR) begin
      bus.rd2_o = '0;
    end else if (BYPASS != 0 && bus.werf_i && bus.rc_i == ra2) begin
      bus.rd2_o = bus.wd_i;
    end
  end

  assign bus.busy_o = busy;
endmodule

// File: tb/tb_regfile_ctrl.sv
module tb_regfile_ctrl;
  import rf_pkg::*;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;
  localparam int ZR   = 31;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  regfile_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
  regfile_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();
  rf_state_e st0, st1;

  // dut0 has bypass, dut1 does not; both see identical stimulus
  regfile_ctrl #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR), .BYPASS(1)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(if0.slave), .state_o(st0));
  regfile_ctrl #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR), .BYPASS(0)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(if1.slave), .state_o(st1));

  assign if1.ra_i     = if0.ra_i;
  assign if1.rb_i     = if0.rb_i;
  assign if1.rc_i     = if0.rc_i;
  assign if1.ra2sel_i = if0.ra2sel_i;
  assign if1.werf_i   = if0.werf_i;
  assign if1.wd_i     = if0.wd_i;
  assign if1.clr_i    = if0.clr_i;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [NREG];
  int            busy_left;        // edges remaining until the clear completes
  logic [DW-1:0] exp_q [$];

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (busy_left > 0) return '0;
    if (int'(a) == ZR) return '0;
    if (byp && if0.werf_i && if0.rc_i == a) return if0.wd_i;
    return ref_mem[a];
  endfunction

  function automatic logic [AW-1:0] ra2_addr();
    return if0.ra2sel_i ? if0.rc_i : if0.rb_i;
  endfunction

  task automatic model_clear();
    busy_left = NREG;
    for (int i = 0; i < NREG; i++) ref_mem[i] = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_clear();
    else if (busy_left > 0) busy_left--;
    else if (if0.clr_i) model_clear();
    else if (if0.werf_i && int'(if0.rc_i) != ZR) ref_mem[if0.rc_i] = if0.wd_i;
    #1;
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d);
    if0.werf_i = 1'b1;
    if0.rc_i   = AW'(a);
    if0.wd_i   = d;
    tick();
    if0.werf_i = 1'b0;
  endtask

  task automatic drive_idle();
    if0.ra_i = '0; if0.rb_i = '0; if0.rc_i = '0; if0.ra2sel_i = 1'b0;
    if0.werf_i = 1'b0; if0.wd_i = '0; if0.clr_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    drive_idle();
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (if0.busy_o !== 1'b1 || st0 !== RF_CLEAR) begin
      errors++; $display("FAIL reset_busy got busy=%b state=%0d exp busy=1 state=%0d", if0.busy_o, st0, RF_CLEAR);
    end
    checks++;
    if (if0.rd1_o !== '0 || if1.rd2_o !== '0) begin
      errors++; $display("FAIL reset_rd got %h/%h exp 0", if0.rd1_o, if1.rd2_o);
    end
    tick(); tick();
    rst_n = 1'b1;
    n = 0;
    while (if0.busy_o === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n != NREG || if1.busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_busy_len got %0d (dut1 busy=%b) exp %0d", n, if1.busy_o, NREG);
    end
    for (int a = 0; a < NREG; a++) begin
      if0.ra_i = AW'(a); if0.rb_i = AW'(NREG - 1 - a);
      #1;
      checks++;
      if (if0.rd1_o !== '0 || if0.rd2_o !== '0 || if1.rd1_o !== '0 || if1.rd2_o !== '0) begin
        errors++; $display("FAIL reset_zero a=%0d got %h %h %h %h exp 0", a, if0.rd1_o, if0.rd2_o, if1.rd1_o, if1.rd2_o);
      end
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] e;
    do_write(5, 32'hDEADBEEF); exp_q.push_back(32'hDEADBEEF);
    do_write(7, 32'h12345678); exp_q.push_back(32'h12345678);
    if0.ra_i = 5'd5; if0.rb_i = 5'd7; if0.ra2sel_i = 1'b0;
    #1;
    e = exp_q.pop_front();
    checks++;
    if (if0.rd1_o !== e || if1.rd1_o !== e) begin
      errors++; $display("FAIL wr_rd1 got %h/%h exp %h", if0.rd1_o, if1.rd1_o, e);
    end
    e = exp_q.pop_front();
    checks++;
    if (if0.rd2_o !== e || if1.rd2_o !== e) begin
      errors++; $display("FAIL wr_rd2 got %h/%h exp %h", if0.rd2_o, if1.rd2_o, e);
    end
  endtask

  task automatic test_zero_reg();
    logic [DW-1:0] e1;
    do_write(ZR, 32'hFFFFFFFF);
    if0.ra_i = AW'(ZR); if0.rb_i = AW'(ZR);
    #1;
    checks++;
    if (if0.rd1_o !== '0 || if0.rd2_o !== '0 || if1.rd1_o !== '0) begin
      errors++; $display("FAIL zero_reg got %h %h %h exp 0", if0.rd1_o, if0.rd2_o, if1.rd1_o);
    end
    for (int a = 0; a < NREG; a++) begin
      if0.ra_i = AW'(a);
      #1;
      e1 = exp_rd(AW'(a), 1'b0);
      checks++;
      if (if0.rd1_o !== e1 || if1.rd1_o !== e1) begin
        errors++; $display("FAIL zero_reg_others a=%0d got %h/%h exp %h", a, if0.rd1_o, if1.rd1_o, e1);
      end
    end
  endtask

  task automatic test_bypass();
    do_write(3, 32'h0BADF00D);
    if0.werf_i = 1'b1; if0.rc_i = 5'd3; if0.wd_i = 32'hA5A5A5A5;
    if0.ra_i = 5'd3; if0.ra2sel_i = 1'b1;
    #1;
    checks++;
    if (if0.rd1_o !== 32'hA5A5A5A5 || if0.rd2_o !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL bypass_on got %h/%h exp a5a5a5a5", if0.rd1_o, if0.rd2_o);
    end
    checks++;
    if (if1.rd1_o !== 32'h0BADF00D || if1.rd2_o !== 32'h0BADF00D) begin
      errors++; $display("FAIL bypass_off_before got %h/%h exp 0badf00d", if1.rd1_o, if1.rd2_o);
    end
    tick();
    if0.werf_i = 1'b0;
    #1;
    checks++;
    if (if1.rd1_o !== 32'hA5A5A5A5 || if1.rd2_o !== 32'hA5A5A5A5 || if0.rd1_o !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL bypass_after got %h/%h/%h exp a5a5a5a5", if1.rd1_o, if1.rd2_o, if0.rd1_o);
    end
    if0.ra2sel_i = 1'b0;
  endtask

  task automatic test_clear_request();
    int n;
    do_write(9, 32'h00000055);
    if0.ra_i = 5'd9;
    #1;
    checks++;
    if (if0.rd1_o !== 32'h55) begin
      errors++; $display("FAIL clr_pre got %h exp 00000055", if0.rd1_o);
    end
    if0.clr_i = 1'b1;
    tick();
    if0.clr_i = 1'b0;
    n = 0;
    while (if0.busy_o === 1'b1 && n < 100) begin
      n++;
      if0.werf_i = (n == 5);
      if0.rc_i   = 5'd9;
      if0.wd_i   = 32'h77;
      if0.clr_i  = (n == 16);
      tick();
    end
    if0.werf_i = 1'b0; if0.clr_i = 1'b0;
    checks++;
    if (n != NREG || if1.busy_o !== 1'b0 || st0 !== RF_IDLE) begin
      errors++; $display("FAIL clr_busy_len got %0d state=%0d exp %0d state=%0d", n, st0, NREG, RF_IDLE);
    end
    if0.ra_i = 5'd9;
    #1;
    checks++;
    if (if0.rd1_o !== '0 || if1.rd1_o !== '0) begin
      errors++; $display("FAIL clr_r9 got %h/%h exp 0", if0.rd1_o, if1.rd1_o);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    do_write(12, 32'hCAFE0012);
    if0.clr_i = 1'b1;
    tick();
    if0.clr_i = 1'b0;
    repeat (10) tick();
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (if0.busy_o !== 1'b1 || st1 !== RF_CLEAR) begin
      errors++; $display("FAIL midclr_reset got busy=%b state=%0d exp busy=1 state=%0d", if0.busy_o, st1, RF_CLEAR);
    end
    tick(); tick();
    rst_n = 1'b1;
    n = 0;
    while (if0.busy_o === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n != NREG) begin
      errors++; $display("FAIL midclr_busy_len got %0d exp %0d", n, NREG);
    end
    for (int a = 0; a < NREG; a++) begin
      if0.ra_i = AW'(a);
      #1;
      checks++;
      if (if0.rd1_o !== '0 || if1.rd1_o !== '0) begin
        errors++; $display("FAIL midclr_zero a=%0d got %h/%h exp 0", a, if0.rd1_o, if1.rd1_o);
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] e1b, e2b, e1n, e2n;
    for (int i = 0; i < 600; i++) begin
      if0.ra_i     = ($urandom_range(0, 7) == 0) ? AW'(ZR) : AW'($urandom_range(0, NREG - 1));
      if0.rb_i     = AW'($urandom_range(0, NREG - 1));
      if0.rc_i     = ($urandom_range(0, 7) == 0) ? AW'(ZR) : AW'($urandom_range(0, NREG - 1));
      if0.ra2sel_i = 1'($urandom_range(0, 1));
      if0.werf_i   = 1'($urandom_range(0, 1));
      if0.wd_i     = DW'($urandom);
      if0.clr_i    = ($urandom_range(0, 79) == 0);
      #1;
      e1b = exp_rd(if0.ra_i, 1'b1);
      e2b = exp_rd(ra2_addr(), 1'b1);
      e1n = exp_rd(if0.ra_i, 1'b0);
      e2n = exp_rd(ra2_addr(), 1'b0);
      checks++;
      if (if0.rd1_o !== e1b || if0.rd2_o !== e2b || if0.busy_o !== (busy_left > 0)) begin
        errors++; $display("FAIL rand_byp i=%0d got %h %h %b exp %h %h %b", i, if0.rd1_o, if0.rd2_o, if0.busy_o, e1b, e2b, busy_left > 0);
      end
      checks++;
      if (if1.rd1_o !== e1n || if1.rd2_o !== e2n || if1.busy_o !== (busy_left > 0)) begin
        errors++; $display("FAIL rand_nobyp i=%0d got %h %h %b exp %h %h %b", i, if1.rd1_o, if1.rd2_o, if1.busy_o, e1n, e2n, busy_left > 0);
      end
      tick();
    end
    drive_idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    drive_idle();
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_clear_request();
    test_reset_mid_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout exp completion before 500000");
    $fatal(1, "timeout");
  end
endmodule
